// File: rtl/valu_iter_divsqrt.sv
// valu_iter_divsqrt: iterative unsigned VDIV/VMOD/VSQRT, one result bit per cycle per lane.
// Optional macro VALU_DIVZ_FLAG_EN adds the per-lane divide-by-zero output divz.
module valu_iter_divsqrt #(
  parameter int DATA_W    = 64,
  parameter int LANES_MAX = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:DATA_W-1] rA_val,
  input  logic [0:DATA_W-1] rB_val,
  input  logic [5:0]        R_ins,
  input  logic [1:0]        WW,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef VALU_DIVZ_FLAG_EN
  output logic [LANES_MAX-1:0] divz,
`endif
  output logic [0:DATA_W-1] result
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {OP_DIV, OP_MOD, OP_SQRT, OP_ILL} op_t;

  state_t state, state_n;
  op_t op_q, op_n, op_dec;
  logic [1:0] ww_q, ww_n;
  logic [6:0] cnt_q, cnt_n;
  logic [DATA_W-1:0] a_q, b_q, r_q;
  logic [DATA_W-1:0] a_n, b_n, r_n, res;
  logic [3:0][DATA_W-1:0] da, dr, sa, sr, sb;

  // a: dividend shifting out / quotient shifting in; b: divisor or root
  for (genvar k = 0; k < 4; k++) begin : g_w
    localparam int W = 8 << k;
    localparam int H = W / 2;
    for (genvar j = 0; j < DATA_W / W; j++) begin : g_l
      localparam int L = j * W;
      logic [W:0] drs, dbv, ddf;
      logic [H+1:0] srs, stv, sdf;
      logic dge, sge;
      assign drs = {r_q[L+:W], a_q[L+W-1]};
      assign dbv = {1'b0, b_q[L+:W]};
      assign ddf = drs - dbv;
      assign dge = drs >= dbv;
      assign da[k][L+:W] = {a_q[L+:W-1], dge};
      assign dr[k][L+:W] = dge ? ddf[W-1:0] : drs[W-1:0];
      assign srs = {r_q[L+:H], a_q[L+W-1-:2]};
      assign stv = {b_q[L+:H], 2'b01};
      assign sdf = srs - stv;
      assign sge = srs >= stv;
      assign sa[k][L+:W] = {a_q[L+:W-2], 2'b00};
      assign sr[k][L+:W] = {{(W-H-2){1'b0}}, sge ? sdf : srs};
      assign sb[k][L+:W] = {{H{1'b0}}, b_q[L+:H-1], sge};
    end
  end

  always_comb begin
    unique case (R_ins)
      6'b001110: op_dec = OP_DIV;
      6'b001111: op_dec = OP_MOD;
      6'b010010: op_dec = OP_SQRT;
      default:   op_dec = OP_ILL;
    endcase
  end

  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == DONE) && !reset;

  always_comb begin
    state_n = state;
    op_n    = op_q;
    ww_n    = ww_q;
    cnt_n   = cnt_q;
    a_n     = a_q;
    b_n     = b_q;
    r_n     = r_q;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          op_n    = op_dec;
          ww_n    = WW;
          a_n     = rA_val;
          b_n     = (op_dec == OP_SQRT) ? '0 : rB_val;
          r_n     = '0;
          cnt_n   = (op_dec == OP_SQRT) ? (7'd4 << WW) : (7'd8 << WW);
          state_n = (op_dec == OP_ILL) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt_q == 7'd0) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt_q - 7'd1;
          if (op_q == OP_SQRT) begin
            a_n = sa[ww_q];
            r_n = sr[ww_q];
            b_n = sb[ww_q];
          end else begin
            a_n = da[ww_q];
            r_n = dr[ww_q];
          end
        end
      end
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_q  <= OP_ILL;
      ww_q  <= '0;
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
    end else begin
      state <= state_n;
      op_q  <= op_n;
      ww_q  <= ww_n;
      cnt_q <= cnt_n;
      a_q   <= a_n;
      b_q   <= b_n;
      r_q   <= r_n;
    end
  end

  always_comb begin
    res = '0;
    if (out_valid) begin
      unique case (op_q)
        OP_DIV:  res = a_q;
        OP_MOD:  res = r_q;
        OP_SQRT: res = b_q;
        default: res = '0;
      endcase
    end
  end
  assign result = res;

`ifdef VALU_DIVZ_FLAG_EN
  logic [3:0][LANES_MAX-1:0] zf;
  for (genvar k = 0; k < 4; k++) begin : g_z
    localparam int W = 8 << k;
    localparam int N = DATA_W / W;
    for (genvar j = 0; j < N; j++) begin : g_zl
      assign zf[k][N-1-j] = (b_q[j*W+:W] == '0);
    end
    for (genvar u = N; u < LANES_MAX; u++) begin : g_zu
      assign zf[k][u] = 1'b0;
    end
  end
  assign divz = (out_valid && (op_q == OP_DIV || op_q == OP_MOD)) ?
                zf[ww_q] : '0;
`endif
endmodule

// File: tb/tb_valu_iter_divsqrt.sv
// tb_valu_iter_divsqrt: randomized and directed checks of valu_iter_divsqrt
// against a lane-wise arithmetic reference model.
module tb_valu_iter_divsqrt;
  localparam int DW = 64;
  localparam int LM = DW / 8;
  localparam logic [5:0] F_DIV  = 6'b001110;
  localparam logic [5:0] F_MOD  = 6'b001111;
  localparam logic [5:0] F_SQRT = 6'b010010;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready;
  logic [0:DW-1] rA_val, rB_val, result;
  logic [5:0] R_ins;
  logic [1:0] WW;
  logic [LM-1:0] last_dz;
`ifdef VALU_DIVZ_FLAG_EN
  logic [LM-1:0] divz;
`endif
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  valu_iter_divsqrt #(.DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .rA_val(rA_val), .rB_val(rB_val),
    .R_ins(R_ins), .WW(WW),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef VALU_DIVZ_FLAG_EN
    .divz(divz),
`endif
    .result(result)
  );

  function automatic logic [63:0] isqrt(input logic [63:0] x);
    logic [63:0] r, c;
    logic [127:0] sq;
    r = '0;
    for (int bt = 31; bt >= 0; bt--) begin
      c = r | (64'd1 << bt);
      sq = c * c;
      if (sq <= {64'd0, x}) r = c;
    end
    return r;
  endfunction

  function automatic logic [63:0] lmask(input logic [1:0] w);
    int wd;
    wd = 8 << w;
    return (wd == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << wd) - 64'd1);
  endfunction

  function automatic logic [63:0] model(input logic [5:0] f, input logic [1:0] w,
                                        input logic [63:0] a, input logic [63:0] b);
    int wd, sh;
    logic [63:0] m, x, y, z, r;
    wd = 8 << w;
    m = lmask(w);
    r = '0;
    for (int i = 0; i < 64 / wd; i++) begin
      sh = 64 - (i + 1) * wd;
      x = (a >> sh) & m;
      y = (b >> sh) & m;
      if (f == F_DIV) z = (y == 0) ? m : x / y;
      else if (f == F_MOD) z = (y == 0) ? x : x % y;
      else if (f == F_SQRT) z = isqrt(x);
      else z = '0;
      r |= z << sh;
    end
    return r;
  endfunction

  function automatic logic [LM-1:0] model_dz(input logic [5:0] f, input logic [1:0] w,
                                             input logic [63:0] b);
    int wd, sh;
    logic [LM-1:0] z;
    wd = 8 << w;
    z = '0;
    if (f == F_DIV || f == F_MOD)
      for (int i = 0; i < 64 / wd; i++) begin
        sh = 64 - (i + 1) * wd;
        z[i] = (((b >> sh) & lmask(w)) == 0);
      end
    return z;
  endfunction

  function automatic int model_lat(input logic [5:0] f, input logic [1:0] w);
    if (f == F_DIV || f == F_MOD) return (8 << w) + 1;
    if (f == F_SQRT) return (4 << w) + 1;
    return 1;
  endfunction

  task automatic do_op(input logic [5:0] f, input logic [1:0] w,
                       input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output int lat);
    int n;
    @(negedge clk);
    in_valid = 1'b1; R_ins = f; WW = w; rA_val = a; rB_val = b;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rA_val = {$urandom, $urandom};
    rB_val = {$urandom, $urandom};
    R_ins = 6'($urandom);
    WW = 2'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 300);
    res = result;
    last_dz = '0;
`ifdef VALU_DIVZ_FLAG_EN
    last_dz = divz;
`endif
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    rA_val = '0; rB_val = '0; R_ins = '0; WW = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== '0) begin
      bad++;
      $display("FAIL reset_state got rdy=%b vld=%b res=%h want 0 0 0",
               in_ready, out_valid, result);
    end
`ifdef VALU_DIVZ_FLAG_EN
    total++;
    if (divz !== '0) begin
      bad++;
      $display("FAIL reset_divz got=%h want=0", divz);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_directed;
    logic [63:0] r;
    int lat;
    do_op(F_DIV, 2'b00, 64'hFF00FF00_FF00FF00, 64'h11221122_44444444, r, lat);
    total++;
    if (r !== 64'h0F000F00_03000300 || lat != 9) begin
      bad++;
      $display("FAIL vdiv8 got=%h lat=%0d want=0f000f0003000300 lat=9", r, lat);
    end
    do_op(F_MOD, 2'b11, 64'd102, 64'd10, r, lat);
    total++;
    if (r !== 64'd2 || lat != 65) begin
      bad++;
      $display("FAIL vmod64 got=%h lat=%0d want=2 lat=65", r, lat);
    end
    do_op(F_DIV, 2'b11, 64'd102, 64'd10, r, lat);
    total++;
    if (r !== 64'd10) begin
      bad++;
      $display("FAIL vdiv64 got=%h want=a", r);
    end
    do_op(F_DIV, 2'b10, 64'h00000007_00000064, 64'h00000000_0000000A, r, lat);
    total++;
    if (r !== 64'hFFFFFFFF_0000000A) begin
      bad++;
      $display("FAIL divz_vdiv got=%h want=ffffffff0000000a", r);
    end
`ifdef VALU_DIVZ_FLAG_EN
    total++;
    if (last_dz !== 8'h01) begin
      bad++;
      $display("FAIL divz_flag got=%h want=01", last_dz);
    end
`endif
    do_op(F_MOD, 2'b10, 64'h00000007_00000064, 64'h00000000_0000000A, r, lat);
    total++;
    if (r !== 64'h00000007_00000000) begin
      bad++;
      $display("FAIL divz_vmod got=%h want=0000000700000000", r);
    end
    do_op(F_SQRT, 2'b10, 64'h00000040_00000001, 64'hDEAD, r, lat);
    total++;
    if (r !== 64'h00000008_00000001 || lat != 17) begin
      bad++;
      $display("FAIL vsqrt32 got=%h lat=%0d want=0000000800000001 lat=17", r, lat);
    end
    do_op(6'b000001, 2'b01, 64'h1234, 64'h1, r, lat);
    total++;
    if (r !== '0 || lat != 1) begin
      bad++;
      $display("FAIL illegal got=%h lat=%0d want=0 lat=1", r, lat);
    end
  endtask

  task automatic test_random;
    logic [63:0] a, b, r, m, e;
    logic [5:0] f;
    logic [1:0] w;
    int lat, sel, wd;
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 9);
      f = (sel < 3) ? F_DIV : (sel < 6) ? F_MOD : (sel < 9) ? F_SQRT : 6'b111111;
      w = 2'($urandom);
      wd = 8 << w;
      m = lmask(w);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      for (int i = 0; i < 64 / wd; i++)
        if ($urandom_range(0, 3) == 0) b &= ~(m << (64 - (i + 1) * wd));
      e = model(f, w, a, b);
      do_op(f, w, a, b, r, lat);
      total++;
      if (r !== e || lat != model_lat(f, w)) begin
        bad++;
        $display("FAIL random f=%b ww=%0d a=%h b=%h got=%h lat=%0d want=%h lat=%0d",
                 f, w, a, b, r, lat, e, model_lat(f, w));
      end
`ifdef VALU_DIVZ_FLAG_EN
      total++;
      if (last_dz !== model_dz(f, w, b)) begin
        bad++;
        $display("FAIL random_divz got=%h want=%h", last_dz, model_dz(f, w, b));
      end
`endif
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] held, e;
    int n;
    e = model(F_DIV, 2'b01, 64'hFFFF_1234_0100_8000, 64'h0003_0011_0000_0100);
    @(negedge clk);
    in_valid = 1'b1; R_ins = F_DIV; WW = 2'b01;
    rA_val = 64'hFFFF_1234_0100_8000; rB_val = 64'h0003_0011_0000_0100;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    held = result;
    total++;
    if (held !== e) begin
      bad++;
      $display("FAIL bp_result got=%h want=%h", held, e);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rA_val = {$urandom, $urandom};
      rB_val = {$urandom, $urandom};
      in_valid = 1'($urandom);
      @(posedge clk);
      #1;
      total++;
      if (result !== e || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold c=%0d got=%h rdy=%b vld=%b want=%h 0 1",
                 c, result, in_ready, out_valid, e);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_release got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] r;
    int lat;
    bit seen;
    @(negedge clk);
    in_valid = 1'b1; R_ins = F_DIV; WW = 2'b11;
    rA_val = 64'd1000; rB_val = 64'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== '0) begin
      bad++;
      $display("FAIL mid_reset got rdy=%b vld=%b res=%h want 0 0 0",
               in_ready, out_valid, result);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_release in_ready got=%b want=1", in_ready);
    end
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || result !== '0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL mid_abort got partial result seen=1 want=0");
    end
    do_op(F_MOD, 2'b11, 64'd102, 64'd10, r, lat);
    total++;
    if (r !== 64'd2) begin
      bad++;
      $display("FAIL mid_after got=%h want=2", r);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
